// File: rtl/nn_pkg.sv
// nn_pkg: shared word types, fixed-point constants and the saturate/ReLU
// helpers used by neural_network_core and nn_layer.
package nn_pkg;

   localparam int NN_BIT_SIZE   = 16;
   localparam int NN_LAYER_SIZE = 4;

   // Fraction bits of the Q-format: half of the word is fraction.
   function automatic int frac_bits(input int bit_size);
      return bit_size / 2;
   endfunction

   localparam int FRAC_BITS = frac_bits(NN_BIT_SIZE);

   // Default-width word and accumulator types.
   typedef logic signed [NN_BIT_SIZE-1:0] word_t;
   typedef logic signed [2*NN_BIT_SIZE+$clog2(NN_LAYER_SIZE)-1:0] acc_t;

   // Helpers work on a 64-bit carrier so they serve any layer width whose
   // accumulator fits in 64 bits (BIT_SIZE up to about 30).
   localparam int WIDE_W = 64;
   typedef logic signed [WIDE_W-1:0] wide_t;

   // Clamp v into the signed range of a bits-wide word.
   function automatic wide_t sat(input wide_t v, input int bits);
      wide_t hi;
      wide_t lo;
      hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (bits - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      return v;
   endfunction

   // Rectifier: negative values become zero.
   function automatic wide_t relu(input wide_t v);
      return v[WIDE_W-1] ? '0 : v;
   endfunction

endpackage

// File: rtl/neural_network_core_layer.sv
// nn_layer: one FIR-style neuron. Holds the delay line of past inputs,
// multiplies every tap by its weight at full precision, rescales by the
// fraction width (floor), saturates, applies the activation and registers
// the result. Activation is ReLU when NN_RELU_EN is defined, else linear.
module nn_layer
   import nn_pkg::*;
#(
   parameter int LAYER_SIZE = 4,
   parameter int BIT_SIZE   = 16
)
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [LAYER_SIZE*BIT_SIZE-1:0] weights,
   input  logic [BIT_SIZE-1:0]            in_word,
   output logic [BIT_SIZE-1:0]            out_word
);

   localparam int FRAC   = frac_bits(BIT_SIZE);
   localparam int PROD_W = 2 * BIT_SIZE;
   localparam int SUM_W  = PROD_W + $clog2(LAYER_SIZE);

   // delay_reg[k] holds the input seen k+1 edges ago.
   logic signed [BIT_SIZE-1:0] delay_reg [LAYER_SIZE-1];
   logic signed [BIT_SIZE-1:0] tap [LAYER_SIZE];
   logic signed [PROD_W-1:0]   prod [LAYER_SIZE];
   logic signed [SUM_W-1:0]    sum;
   logic signed [SUM_W-1:0]    shifted;
   wide_t                      clamped;
   wide_t                      activated;
   logic [BIT_SIZE-1:0]        out_reg;
   logic [BIT_SIZE-1:0]        out_next;

   assign tap[0] = $signed(in_word);

   generate
      for (genvar gi = 1; gi < LAYER_SIZE; gi++) begin : g_tap
         assign tap[gi] = delay_reg[gi-1];
      end
      for (genvar gi = 0; gi < LAYER_SIZE; gi++) begin : g_mul
         assign prod[gi] = PROD_W'($signed(weights[gi*BIT_SIZE +: BIT_SIZE])) * PROD_W'(tap[gi]);
      end
   endgenerate

   // Full-precision sum of all tap products
   always_comb begin
      sum = '0;
      for (int i = 0; i < LAYER_SIZE; i++)
         sum = sum + SUM_W'(prod[i]);
   end

   // Arithmetic shift rounds toward -inf
   assign shifted = sum >>> FRAC;

   // Saturate to the word range, then apply the activation
   always_comb begin
      clamped = sat(WIDE_W'(shifted), BIT_SIZE);
`ifdef NN_RELU_EN
      activated = relu(clamped);
`else
      activated = clamped;
`endif
      out_next = BIT_SIZE'(activated);
   end

   // Advance the delay line and capture the layer output every cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_reg <= '0;
         for (int i = 0; i < LAYER_SIZE - 1; i++)
            delay_reg[i] <= '0;
      end else begin
         out_reg      <= out_next;
         delay_reg[0] <= tap[0];
         for (int i = 1; i < LAYER_SIZE - 1; i++)
            delay_reg[i] <= delay_reg[i-1];
      end
   end

   assign out_word = out_reg;

endmodule

// File: rtl/neural_network_core.sv
// neural_network_core: LAYER_DEPTH cascaded nn_layer neurons fed either by
// the external sample x or by the network output y (feedback). Holds the
// weight RAM, written and read through the (layer,node) port.
// Build option: define NN_RELU_EN for ReLU activation on every layer;
// leave it undefined for a linear network.
module neural_network_core
   import nn_pkg::*;
#(
   parameter int LAYER_SIZE  = 4,
   parameter int LAYER_DEPTH = 4,
   parameter int BIT_SIZE    = 16
)
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           write_enable,
   input  logic                           input_select,
   input  logic [$clog2(LAYER_DEPTH)-1:0] layer,
   input  logic [$clog2(LAYER_SIZE)-1:0]  node,
   input  logic [BIT_SIZE-1:0]            x,
   output logic [BIT_SIZE-1:0]            y,
   output logic [BIT_SIZE-1:0]            y_mem
);

   logic [BIT_SIZE-1:0]            weight_mem [LAYER_DEPTH][LAYER_SIZE];
   logic [LAYER_SIZE*BIT_SIZE-1:0] layer_weights [LAYER_DEPTH];
   logic [BIT_SIZE-1:0]            layer_in [LAYER_DEPTH];
   logic [BIT_SIZE-1:0]            layer_out [LAYER_DEPTH];
   logic                           addr_ok;

   // Addresses beyond the array (non-power-of-2 sizes) are ignored.
   assign addr_ok = (32'(layer) < LAYER_DEPTH) && (32'(node) < LAYER_SIZE);

   // Weight RAM has no reset: coefficients survive rst and writes land even during rst
   always_ff @(posedge clk) begin
      if (write_enable && addr_ok)
         weight_mem[layer][node] <= x;
   end

   assign y_mem = addr_ok ? weight_mem[layer][node] : '0;

   generate
      for (genvar gi = 0; gi < LAYER_DEPTH; gi++) begin : g_layer
         for (genvar gj = 0; gj < LAYER_SIZE; gj++) begin : g_w
            assign layer_weights[gi][gj*BIT_SIZE +: BIT_SIZE] = weight_mem[gi][gj];
         end

         if (gi == 0) begin : g_head
            // y is a register, so the feedback loop is closed through flops
            assign layer_in[gi] = input_select ? x : y;
         end else begin : g_chain
            assign layer_in[gi] = layer_out[gi-1];
         end

         nn_layer #(
            .LAYER_SIZE (LAYER_SIZE),
            .BIT_SIZE   (BIT_SIZE)
         ) u_layer (
            .clk      (clk),
            .rst      (rst),
            .weights  (layer_weights[gi]),
            .in_word  (layer_in[gi]),
            .out_word (layer_out[gi])
         );
      end
   endgenerate

   assign y = layer_out[LAYER_DEPTH-1];

endmodule

// File: tb/tb_neural_network_core.sv
// tb_neural_network_core: directed + random stimulus; a behavioural model
// predicts y and y_mem for every clock edge into a queue, and an independent
// monitor pops and compares one entry per edge.
module tb_neural_network_core;

   localparam int S = 4;
   localparam int D = 4;
   localparam int B = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        write_enable = 1'b0;
   logic        input_select = 1'b0;
   logic [1:0]  layer = 2'd0;
   logic [1:0]  node = 2'd0;
   logic [15:0] x = 16'd0;
   logic [15:0] y;
   logic [15:0] y_mem;

   neural_network_core #(
      .LAYER_SIZE  (S),
      .LAYER_DEPTH (D),
      .BIT_SIZE    (B)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .write_enable (write_enable),
      .input_select (input_select),
      .layer        (layer),
      .node         (node),
      .x            (x),
      .y            (y),
      .y_mem        (y_mem)
   );

   always #5 clk = ~clk;

   typedef struct {
      int y;
      int ym;
   } exp_t;

   exp_t exp_q[$];
   int total = 0;
   int bad = 0;
   int pushed = 0;
   int popped = 0;

   // Reference state: weights, layer outputs, and per-layer input history
   int m_w    [D][S];
   int m_out  [D];
   int m_past [D][S];

   function automatic int sx16(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   task automatic model_clear();
      for (int i = 0; i < D; i++) begin
         m_out[i] = 0;
         for (int k = 0; k < S; k++) m_past[i][k] = 0;
      end
   endtask

   // One clock edge of the network, computed from the arithmetic rules
   task automatic model_step(input logic r, input logic we, input logic sel,
                             input logic [1:0] l, input logic [1:0] n, input logic [15:0] xv);
      int in_v [D];
      int nxt [D];
      longint acc;
      longint v;
      if (r) begin
         model_clear();
      end else begin
         for (int i = 0; i < D; i++)
            in_v[i] = (i == 0) ? (sel ? sx16(xv) : m_out[D-1]) : m_out[i-1];
         for (int i = 0; i < D; i++) begin
            acc = longint'(m_w[i][0]) * longint'(in_v[i]);
            for (int k = 1; k < S; k++)
               acc += longint'(m_w[i][k]) * longint'(m_past[i][k-1]);
            v = acc / 256;
            if ((acc % 256 != 0) && (acc < 0)) v = v - 1;
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
`ifdef NN_RELU_EN
            if (v < 0) v = 0;
`endif
            nxt[i] = int'(v);
         end
         for (int i = 0; i < D; i++) begin
            for (int k = S - 1; k >= 1; k--) m_past[i][k] = m_past[i][k-1];
            m_past[i][0] = in_v[i];
            m_out[i] = nxt[i];
         end
      end
      if (we) m_w[l][n] = sx16(xv);
   endtask

   task automatic cycle(input logic r, input logic we, input logic sel,
                        input logic [1:0] l, input logic [1:0] n, input logic [15:0] xv);
      exp_t e;
      @(negedge clk);
      rst = r;
      write_enable = we;
      input_select = sel;
      layer = l;
      node = n;
      x = xv;
      @(posedge clk);
      model_step(r, we, sel, l, n, xv);
      e.y = m_out[D-1];
      e.ym = m_w[l][n];
      exp_q.push_back(e);
      pushed++;
   endtask

   task automatic set_w(input logic [1:0] l, input logic [1:0] n, input logic [15:0] v);
      cycle(1'b0, 1'b1, 1'b0, l, n, v);
   endtask

   task automatic set_all(input logic [1:0] l, input logic [15:0] v0, input logic [15:0] vr);
      for (int n = 0; n < S; n++)
         set_w(l, 2'(n), (n == 0) ? v0 : vr);
   endtask

   task automatic run(input logic sel, input logic [15:0] xv, input int count);
      for (int i = 0; i < count; i++)
         cycle(1'b0, 1'b0, sel, 2'd0, 2'd0, xv);
   endtask

   task automatic read(input logic [1:0] l, input logic [1:0] n);
      cycle(1'b0, 1'b0, 1'b0, l, n, 16'd0);
   endtask

   // Assert rst between edges and check y clears without waiting for a clock
   task automatic async_reset();
      @(negedge clk);
      write_enable = 1'b0;
      #2 rst = 1'b1;
      #1;
      total++;
      if (y !== 16'h0000) begin
         bad++;
         $display("FAIL async_rst y=%h want 0000", y);
      end
      model_clear();
   endtask

   // Monitor: one expected entry per edge, compared 1 time unit after it
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            popped++;
            total++;
            if (sx16(y) != e.y) begin
               bad++;
               $display("FAIL y edge=%0d got=%0d want=%0d", popped, sx16(y), e.y);
            end
            total++;
            if (sx16(y_mem) != e.ym) begin
               bad++;
               $display("FAIL y_mem edge=%0d got=%0d want=%0d", popped, sx16(y_mem), e.ym);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout pushed=%0d popped=%0d", pushed, popped);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] xv;
      logic        we;
      model_clear();
      for (int i = 0; i < D; i++)
         for (int k = 0; k < S; k++) m_w[i][k] = 0;

      // Reset state
      @(posedge clk);
      #1;
      total++;
      if (y !== 16'h0000) begin
         bad++;
         $display("FAIL reset_y got=%h want=0000", y);
      end

      // Known weight contents
      for (int l = 0; l < D; l++)
         for (int n = 0; n < S; n++) set_w(2'(l), 2'(n), 16'h0000);

      // Weight write, read-back, retention across rst, write during rst
      set_w(2'd2, 2'd1, 16'h0123);
      set_w(2'd3, 2'd3, 16'h0456);
      read(2'd2, 2'd1);
      read(2'd3, 2'd3);
      async_reset();
      read(2'd2, 2'd1);
      read(2'd3, 2'd3);
      cycle(1'b1, 1'b1, 1'b0, 2'd1, 2'd2, 16'h0789);
      read(2'd1, 2'd2);

      // Impulse through identity layers
      for (int l = 0; l < D; l++) set_all(2'(l), 16'd256, 16'd0);
      async_reset();
      run(1'b1, 16'd512, 1);
      run(1'b1, 16'd0, 8);

      // Ramp: layer 0 sums four taps
      set_all(2'd0, 16'd256, 16'd256);
      async_reset();
      run(1'b1, 16'd256, 10);

      // Activation on a negative input
      set_all(2'd0, 16'd256, 16'd0);
      async_reset();
      run(1'b1, 16'hFF00, 8);

      // Positive and negative saturation
      set_all(2'd0, 16'h7FFF, 16'h7FFF);
      async_reset();
      run(1'b1, 16'h7FFF, 8);
      set_all(2'd0, 16'h8000, 16'h8000);
      async_reset();
      run(1'b1, 16'h7FFF, 8);

      // Feedback loop, then reset mid-run
      set_all(2'd0, 16'd256, 16'd0);
      async_reset();
      run(1'b1, 16'd256, 4);
      run(1'b0, 16'd0, 12);
      async_reset();
      run(1'b0, 16'd0, 2);
      read(2'd0, 2'd0);

      // Mixed pattern: small weights to stay mostly in range
      for (int l = 0; l < D; l++)
         for (int n = 0; n < S; n++)
            set_w(2'(l), 2'(n), 16'($urandom_range(0, 191)) - 16'd64);
      async_reset();
      run(1'b1, 16'h0180, 3);
      run(1'b1, 16'hFE80, 3);
      run(1'b0, 16'd0, 6);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0) async_reset();
         we = ($urandom_range(0, 4) == 0);
         if (we)
            xv = 16'($urandom_range(0, 767)) - 16'd384;
         else if ($urandom_range(0, 1) == 0)
            xv = 16'($urandom);
         else
            xv = 16'($urandom_range(0, 1023)) - 16'd512;
         cycle(($urandom_range(0, 39) == 0), we, 1'($urandom_range(0, 1)),
               2'($urandom), 2'($urandom), xv);
      end

      repeat (3) @(posedge clk);
      #2;
      total++;
      if ((exp_q.size() != 0) || (popped != pushed)) begin
         bad++;
         $display("FAIL drain popped=%0d want=%0d", popped, pushed);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
